// File: rtl/sdram_line_xfer.sv
// Line-transfer Wishbone master to req/ready + rvalid SDRAM request bridge.
// Optional macro LINE_PREFETCH_EN: read lines issue all beats up front and ack from a return buffer.
module sdram_line_xfer #(
    parameter int AWIDTH = 25,
    parameter int DWIDTH = 32,
    parameter int BEATS  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              s_cyc,
    input  logic              s_stb,
    input  logic              s_we,
    input  logic [AWIDTH-1:0] s_adr,
    input  logic [DWIDTH-1:0] s_dat_i,
    output logic [DWIDTH-1:0] s_dat_o,
    output logic              s_ack,
    output logic              m_req,
    output logic              m_we,
    output logic [AWIDTH-1:0] m_adr,
    output logic [DWIDTH-1:0] m_dat_o,
    input  logic              m_ready,
    input  logic              m_rvalid,
    input  logic [DWIDTH-1:0] m_dat_i,
    output logic              busy_o
);
    localparam int BW = $clog2(BEATS);
    localparam int OW = BW + 1;
    localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, CMD, WAIT, ACK, DONE, DRAIN, PF} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [OW-1:0]     out_q, out_d;
    logic [AWIDTH-1:0] base_q, base_d;
    logic              dir_q, dir_d;
    logic [DWIDTH-1:0] dat_q, dat_d;
    logic [BW-1:0]     req_beat;
    logic              pf_req, ack_pf, issue, ret;

`ifdef LINE_PREFETCH_EN
    logic [OW-1:0]     iss_q, iss_d;
    logic [BW-1:0]     ridx_q, ridx_d;
    logic [BEATS-1:0]  vld_q, vld_d;
    logic [DWIDTH-1:0] buf_q [BEATS];
    logic [DWIDTH-1:0] buf_d [BEATS];
    logic              pf_ack_q, pf_ack_d;

    assign pf_req   = (state_q == PF) & (iss_q < OW'(BEATS));
    assign req_beat = (state_q == PF) ? iss_q[BW-1:0] : beat_q;
    assign ack_pf   = pf_ack_q;
`else
    assign pf_req   = 1'b0;
    assign req_beat = beat_q;
    assign ack_pf   = 1'b0;
`endif

    // Request is gated by s_cyc so an abort withdraws it in the same cycle.
    assign m_req   = s_cyc & ((state_q == CMD) | pf_req);
    assign m_we    = m_req & dir_q;
    assign m_adr   = m_req ? {base_q[AWIDTH-1:BW], req_beat} : '0;
    assign m_dat_o = (m_req & dir_q) ? s_dat_i : '0;
    assign s_ack   = s_cyc & ((state_q == ACK) | ack_pf);
    assign s_dat_o = dat_q;
    assign busy_o  = (state_q != IDLE);
    assign issue   = m_req & m_ready & ~dir_q;
    assign ret     = m_rvalid & (out_q != '0);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        dir_d   = dir_q;
        dat_d   = dat_q;
        out_d   = out_q + OW'(issue) - OW'(ret);
`ifdef LINE_PREFETCH_EN
        iss_d    = iss_q;
        ridx_d   = ridx_q;
        vld_d    = vld_q;
        buf_d    = buf_q;
        pf_ack_d = 1'b0;
`endif
        case (state_q)
            IDLE: if (s_cyc & s_stb) begin
                base_d  = {s_adr[AWIDTH-1:BW], {BW{1'b0}}};
                dir_d   = s_we;
                beat_d  = '0;
                state_d = CMD;
`ifdef LINE_PREFETCH_EN
                iss_d  = '0;
                ridx_d = '0;
                vld_d  = '0;
                if (!s_we) state_d = PF;
`endif
            end
            CMD: begin
                if (!s_cyc)       state_d = DRAIN;
                else if (m_ready) state_d = dir_q ? ACK : WAIT;
            end
            WAIT: begin
                if (!s_cyc) state_d = DRAIN;
                else if (ret) begin
                    dat_d   = m_dat_i;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!s_cyc)              state_d = DRAIN;
                else if (beat_q == LAST) state_d = DONE;
                else begin
                    beat_d  = beat_q + BW'(1);
                    state_d = CMD;
                end
            end
            DONE:  if (!s_cyc) state_d = IDLE;
            DRAIN: if (out_q == '0) state_d = IDLE;
`ifdef LINE_PREFETCH_EN
            PF: begin
                if (!s_cyc) begin
                    state_d = DRAIN;
                    vld_d   = '0;
                end else begin
                    if (issue) iss_d = iss_q + OW'(1);
                    // Returns arrive in order, so the return count is the buffer index.
                    if (ret) begin
                        buf_d[ridx_q] = m_dat_i;
                        vld_d[ridx_q] = 1'b1;
                        ridx_d        = ridx_q + BW'(1);
                    end
                    if (vld_q[beat_q]) begin
                        dat_d         = buf_q[beat_q];
                        pf_ack_d      = 1'b1;
                        vld_d[beat_q] = 1'b0;
                        if (beat_q == LAST) state_d = DONE;
                        else                beat_d  = beat_q + BW'(1);
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            beat_q  <= '0;
            out_q   <= '0;
            base_q  <= '0;
            dir_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            out_q   <= out_d;
            base_q  <= base_d;
            dir_q   <= dir_d;
            dat_q   <= dat_d;
        end
    end

`ifdef LINE_PREFETCH_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            iss_q    <= '0;
            ridx_q   <= '0;
            vld_q    <= '0;
            pf_ack_q <= 1'b0;
            for (int i = 0; i < BEATS; i++) buf_q[i] <= '0;
        end else begin
            iss_q    <= iss_d;
            ridx_q   <= ridx_d;
            vld_q    <= vld_d;
            pf_ack_q <= pf_ack_d;
            buf_q    <= buf_d;
        end
    end
`endif
endmodule
